// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the pipelined multi-lane add/subtract unit.
// The lane result struct carries the flag/value split used by both wrap and saturate modes.
package adder_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest lane the result struct can describe; wider builds are rejected at elaboration.
  localparam int unsigned MAX_DATA_WIDTH = 64;

  typedef struct packed {
    logic                      flag;
    logic [MAX_DATA_WIDTH-1:0] value;
  } lane_result_t;

  // Turns the final carry of a lane into carry/borrow and, if enabled, clamps the value.
  function automatic lane_result_t resolve_lane(
    input logic                      sub,
    input logic                      carry,
    input logic [MAX_DATA_WIDTH-1:0] value,
    input int unsigned               width,
    input bit                        saturate
  );
    lane_result_t r;
    r.flag  = (sub == OP_SUB) ? ~carry : carry;
    r.value = value;
    if (saturate && r.flag) begin
      r.value = (sub == OP_SUB) ? '0 : ({MAX_DATA_WIDTH{1'b1}} >> (MAX_DATA_WIDTH - width));
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline slot: computes chunk IDX of every lane from the carry of the previous slot
// and carries the operands forward for the remaining chunks.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned LANES      = 1,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned IDX        = 0,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        up_valid,
  input  logic                        up_sub,
  input  logic [LANES*DATA_WIDTH-1:0] up_a,
  input  logic [LANES*DATA_WIDTH-1:0] up_b,
  input  logic [LANES*DATA_WIDTH-1:0] up_res,
  input  logic [LANES-1:0]            up_carry,
  input  logic                        down_ready,
  output logic                        ready,
  output logic                        valid,
  output logic                        sub,
  output logic [LANES*DATA_WIDTH-1:0] a,
  output logic [LANES*DATA_WIDTH-1:0] b,
  output logic [LANES*DATA_WIDTH-1:0] res,
  output logic [LANES-1:0]            carry
);

  localparam int unsigned CW      = DATA_WIDTH / STAGES;
  localparam bit          IS_LAST = (IDX == STAGES - 1);

  logic [CW-1:0]               a_chunk;
  logic [CW-1:0]               b_chunk;
  logic [CW-1:0]               sum_chunk;
  logic                        cin;
  logic                        cout;
  logic [LANES*DATA_WIDTH-1:0] nxt_res;
  logic [LANES-1:0]            nxt_carry;
  logic [MAX_DATA_WIDTH-1:0]   lane_ext;
  lane_result_t                lane_r;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    nxt_res   = up_res;
    nxt_carry = '0;
    a_chunk   = '0;
    b_chunk   = '0;
    sum_chunk = '0;
    cin       = 1'b0;
    cout      = 1'b0;
    lane_ext  = '0;
    lane_r    = '0;
    for (int l = 0; l < LANES; l++) begin
      a_chunk = up_a[l*DATA_WIDTH + IDX*CW +: CW];
      b_chunk = up_b[l*DATA_WIDTH + IDX*CW +: CW] ^ {CW{up_sub}};
      cin     = (IDX == 0) ? up_sub : up_carry[l];
      {cout, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, cin};
      nxt_res[l*DATA_WIDTH + IDX*CW +: CW] = sum_chunk;
      // The last slot owns the full lane value, so the wrap/saturate decision lives here.
      if (IS_LAST) begin
        lane_ext                          = '0;
        lane_ext[DATA_WIDTH-1:0]          = nxt_res[l*DATA_WIDTH +: DATA_WIDTH];
        lane_r                            = resolve_lane(up_sub, cout, lane_ext, DATA_WIDTH, SATURATE);
        nxt_res[l*DATA_WIDTH +: DATA_WIDTH] = lane_r.value[DATA_WIDTH-1:0];
        nxt_carry[l]                      = lane_r.flag;
      end else begin
        nxt_carry[l] = cout;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lane_r.value, up_carry};

  // Accept when empty or when the current occupant moves on this cycle.
  assign ready = ~valid | down_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: datapath registers are reset as well, so sum_o reads zero while rst_i is high.
      valid <= 1'b0;
      sub   <= 1'b0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      carry <= '0;
    end else if (ready) begin
      // NOTE: non-blocking, so every slot samples its neighbour's pre-edge value.
      valid <= up_valid;
      if (up_valid) begin
        sub   <= up_sub;
        a     <= up_a;
        b     <= up_b;
        res   <= nxt_res;
        carry <= nxt_carry;
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Multi-lane pipelined unsigned add/subtract with valid/ready on both sides.
// Each lane is split into STAGES carry-chained chunks, one chunk per pipeline slot.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned LANES      = 1,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            v_i,
  output logic                            ready_o,
  input  logic                            sub_i,
  input  logic [LANES*DATA_WIDTH-1:0]     a_i,
  input  logic [LANES*DATA_WIDTH-1:0]     b_i,
  output logic                            v_o,
  input  logic                            ready_i,
  output logic [LANES*(DATA_WIDTH+1)-1:0] sum_o
);

  localparam int unsigned LW = LANES * DATA_WIDTH;

  if (STAGES < 1) begin : g_bad_stages
    $error("adder_pipe: STAGES must be at least 1");
  end else if ((DATA_WIDTH % STAGES) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("adder_pipe: DATA_WIDTH must be a multiple of STAGES and fit MAX_DATA_WIDTH");
  end

  logic             st_valid [STAGES];
  logic             st_ready [STAGES];
  logic             st_sub   [STAGES];
  logic [LW-1:0]    st_a     [STAGES];
  logic [LW-1:0]    st_b     [STAGES];
  logic [LW-1:0]    st_res   [STAGES];
  logic [LANES-1:0] st_carry [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             up_valid;
    logic             up_sub;
    logic [LW-1:0]    up_a;
    logic [LW-1:0]    up_b;
    logic [LW-1:0]    up_res;
    logic [LANES-1:0] up_carry;
    logic             down_ready;

    if (s == 0) begin : g_first
      assign up_valid = v_i;
      assign up_sub   = sub_i;
      assign up_a     = a_i;
      assign up_b     = b_i;
      assign up_res   = '0;
      assign up_carry = '0;
    end else begin : g_chain
      assign up_valid = st_valid[s-1];
      assign up_sub   = st_sub[s-1];
      assign up_a     = st_a[s-1];
      assign up_b     = st_b[s-1];
      assign up_res   = st_res[s-1];
      assign up_carry = st_carry[s-1];
    end

    if (s == STAGES - 1) begin : g_tail
      assign down_ready = ready_i;
    end else begin : g_inner
      assign down_ready = st_ready[s+1];
    end

    adder_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .STAGES     (STAGES),
      .IDX        (s),
      .SATURATE   (SATURATE != 0)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .up_valid   (up_valid),
      .up_sub     (up_sub),
      .up_a       (up_a),
      .up_b       (up_b),
      .up_res     (up_res),
      .up_carry   (up_carry),
      .down_ready (down_ready),
      .ready      (st_ready[s]),
      .valid      (st_valid[s]),
      .sub        (st_sub[s]),
      .a          (st_a[s]),
      .b          (st_b[s]),
      .res        (st_res[s]),
      .carry      (st_carry[s])
    );
  end

  assign ready_o = st_ready[0];
  assign v_o     = st_valid[STAGES-1];

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_o[l*(DATA_WIDTH+1) +: DATA_WIDTH+1] =
        {st_carry[STAGES-1][l], st_res[STAGES-1][l*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // Operands and op select are no longer needed once the last chunk is done.
  logic unused_tail;
  assign unused_tail = ^{st_sub[STAGES-1], st_a[STAGES-1], st_b[STAGES-1]};

endmodule
